// File: rtl/i2s_pkg.sv
// Shared I2S types and default framing constants for the receive and transmit paths.
package i2s_pkg;

  typedef enum logic [1:0] {UNSYNC, LEFT, RIGHT} rx_state_t;

  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned SLOT_BITS  = 16;
  localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned CNT_W      = 6;

endpackage

// File: rtl/i2s_slot_deserializer.sv
// MSB-first slot capture: counts bits since the last word-select transition and
// presents the slot word including the bit sampled on the current edge.
module i2s_slot_deserializer
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SAMPLE_W
) (
  input  logic                  serial_clk,
  input  logic                  reset,
  input  logic                  bit_in,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] word,
  output logic [CNT_W-1:0]      slot_len
);

  logic [CNT_W-1:0]      count_q;
  logic [DATA_WIDTH-1:0] shift_q;

  // Bits past DATA_WIDTH shift out of range and are dropped.
  assign word     = shift_q | ({bit_in, {(DATA_WIDTH-1){1'b0}}} >> count_q);
  assign slot_len = (count_q == '1) ? count_q : count_q + CNT_W'(1);

  always_ff @(posedge serial_clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      shift_q <= '0;
    end else if (clear) begin
      count_q <= '0;
      shift_q <= '0;
    end else begin
      count_q <= slot_len;
      shift_q <= word;
    end
  end

endmodule

// File: rtl/i2s_receiver.sv
// Slave I2S receiver: frame lock FSM, left holding register, mono average and
// saturating framing-error counter on top of the slot deserializer.
module i2s_receiver
  import i2s_pkg::rx_state_t, i2s_pkg::UNSYNC, i2s_pkg::LEFT, i2s_pkg::RIGHT,
         i2s_pkg::SAMPLE_W, i2s_pkg::CNT_W;
#(
  parameter int unsigned DATA_WIDTH    = SAMPLE_W,
  parameter int unsigned SLOT_BITS     = i2s_pkg::SLOT_BITS,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     serial_clk,
  input  logic                     reset,
  input  logic                     sound_bit_in,
  input  logic                     word_select_in,
  output logic [DATA_WIDTH-1:0]    left_sample,
  output logic [DATA_WIDTH-1:0]    right_sample,
  output logic [DATA_WIDTH-1:0]    mono_sample,
  output logic                     sample_valid,
  output logic                     locked,
  output logic                     frame_error,
  output logic [ERR_CNT_WIDTH-1:0] error_count
);

  rx_state_t                  state_q;
  logic                       ws_q;
  logic                       left_ok_q;
  logic [DATA_WIDTH-1:0]      left_hold_q;
  logic [DATA_WIDTH-1:0]      slot_word;
  logic [DATA_WIDTH-1:0]      mono_next;
  logic signed [DATA_WIDTH:0] pair_sum;
  logic [CNT_W-1:0]           slot_len;
  logic [ERR_CNT_WIDTH-1:0]   err_inc;
  logic                       transition;
  logic                       ws_fall;
  logic                       slot_ok;
  logic                       stuck;

  assign transition = (word_select_in != ws_q);
  assign ws_fall    = transition && !word_select_in;
  assign slot_ok    = (slot_len == CNT_W'(SLOT_BITS));
  assign stuck      = (slot_len >= CNT_W'(2 * SLOT_BITS));
  assign err_inc    = (error_count == '1) ? error_count : error_count + ERR_CNT_WIDTH'(1);

  // Sign-extended sum cannot overflow; dropping bit 0 is the floor halving.
  assign pair_sum  = $signed({left_hold_q[DATA_WIDTH-1], left_hold_q})
                   + $signed({slot_word[DATA_WIDTH-1], slot_word});
  assign mono_next = pair_sum[DATA_WIDTH:1];

  i2s_slot_deserializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_slot (
    .serial_clk(serial_clk),
    .reset     (reset),
    .bit_in    (sound_bit_in),
    .clear     (transition),
    .word      (slot_word),
    .slot_len  (slot_len)
  );

  always_ff @(posedge serial_clk or posedge reset) begin
    if (reset) begin
      state_q      <= UNSYNC;
      ws_q         <= 1'b0;
      left_ok_q    <= 1'b0;
      left_hold_q  <= '0;
      left_sample  <= '0;
      right_sample <= '0;
      mono_sample  <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
      frame_error  <= 1'b0;
      error_count  <= '0;
    end else begin
      ws_q         <= word_select_in;
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;
      unique case (state_q)
        UNSYNC: begin
          if (ws_fall) begin
            state_q <= LEFT;
            locked  <= 1'b1;
          end
        end
        LEFT: begin
          if (transition) begin
            left_hold_q <= slot_word;
            left_ok_q   <= slot_ok;
            state_q     <= RIGHT;
          end else if (stuck) begin
            frame_error <= 1'b1;
            error_count <= err_inc;
            state_q     <= UNSYNC;
            locked      <= 1'b0;
          end
        end
        RIGHT: begin
          if (transition) begin
            if (slot_ok && left_ok_q) begin
              left_sample  <= left_hold_q;
              right_sample <= slot_word;
              mono_sample  <= mono_next;
              sample_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
              error_count <= err_inc;
            end
            state_q <= LEFT;
          end else if (stuck) begin
            frame_error <= 1'b1;
            error_count <= err_inc;
            state_q     <= UNSYNC;
            locked      <= 1'b0;
          end
        end
        default: begin
          state_q <= UNSYNC;
          locked  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Frame-level bench for i2s_receiver: builds I2S slots, predicts emitted pairs and
// framing errors per frame, and checks outputs from a negedge monitor.
module tb_i2s_receiver;

  logic        serial_clk;
  logic        reset;
  logic        sound_bit_in;
  logic        word_select_in;
  logic [15:0] left_sample;
  logic [15:0] right_sample;
  logic [15:0] mono_sample;
  logic        sample_valid;
  logic        locked;
  logic        frame_error;
  logic [7:0]  error_count;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          at;
  } pair_t;

  pair_t       exp_q[$];
  int          err_q[$];
  int          n_checks;
  int          n_errors;
  int          edge_n;
  int          errs;
  bit          synced;
  logic [15:0] last_l;
  logic [15:0] last_r;
  pair_t       mon_e;
  int          mon_k;

  i2s_receiver #(
    .DATA_WIDTH   (16),
    .SLOT_BITS    (16),
    .ERR_CNT_WIDTH(8)
  ) dut (
    .serial_clk    (serial_clk),
    .reset         (reset),
    .sound_bit_in  (sound_bit_in),
    .word_select_in(word_select_in),
    .left_sample   (left_sample),
    .right_sample  (right_sample),
    .mono_sample   (mono_sample),
    .sample_valid  (sample_valid),
    .locked        (locked),
    .frame_error   (frame_error),
    .error_count   (error_count)
  );

  initial begin
    serial_clk = 1'b0;
    forever #5 serial_clk = ~serial_clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // floor((l + r) / 2) on signed values, via truncating division plus correction.
  function automatic logic [15:0] mono_of(input logic [15:0] l, input logic [15:0] r);
    int s;
    s = int'($signed(l)) + int'($signed(r));
    if (s < 0 && (s % 2) != 0) s = s - 1;
    return 16'(s / 2);
  endfunction

  task automatic drive_edge(input logic ws, input logic b);
    word_select_in = ws;
    sound_bit_in   = b;
    @(posedge serial_clk);
    edge_n++;
    @(negedge serial_clk);
  endtask

  // Word select flips on the slot's last bit, one edge ahead of the next MSB.
  task automatic send_slot(input logic chan, input logic [15:0] val, input int len);
    for (int i = 0; i < len; i++) begin
      logic b;
      b = (i < 16) ? val[4'(15 - i)] : 1'($urandom);
      drive_edge((i == len - 1) ? ~chan : chan, b);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input int llen,
                            input logic [15:0] r, input int rlen);
    send_slot(1'b0, l, llen);
    if (synced) begin
      if (llen == 16 && rlen == 16) begin
        exp_q.push_back('{l: l, r: r, at: edge_n + rlen});
      end else begin
        err_q.push_back(edge_n + rlen);
        errs++;
      end
    end
    send_slot(1'b1, r, rlen);
    synced = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_left"}, left_sample, 16'h0);
    check_eq({tag, "_right"}, right_sample, 16'h0);
    check_eq({tag, "_mono"}, mono_sample, 16'h0);
    check_eq({tag, "_valid"}, sample_valid, 1'b0);
    check_eq({tag, "_locked"}, locked, 1'b0);
    check_eq({tag, "_ferr"}, frame_error, 1'b0);
    check_eq({tag, "_errcnt"}, error_count, 8'h0);
  endtask

  always @(negedge serial_clk) begin
    if (reset) begin
      last_l = '0;
      last_r = '0;
    end else begin
      if (sample_valid) begin
        check_eq("valid_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check_eq("valid_edge", edge_n, mon_e.at);
          check_eq("left_sample", left_sample, mon_e.l);
          check_eq("right_sample", right_sample, mon_e.r);
          check_eq("mono_sample", mono_sample, mono_of(mon_e.l, mon_e.r));
          last_l = mon_e.l;
          last_r = mon_e.r;
        end
      end
      if (frame_error) begin
        check_eq("error_expected", 32'(err_q.size() != 0), 32'd1);
        if (err_q.size() != 0) begin
          mon_k = err_q.pop_front();
          check_eq("error_edge", edge_n, mon_k);
          check_eq("hold_left", left_sample, last_l);
          check_eq("hold_right", right_sample, last_r);
        end
      end
    end
  end

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    edge_n         = 0;
    errs           = 0;
    synced         = 1'b0;
    reset          = 1'b1;
    word_select_in = 1'b0;
    sound_bit_in   = 1'b0;
    repeat (3) @(negedge serial_clk);
    check_all_zero("reset");
    reset = 1'b0;

    repeat (3) send_frame(16'h1234, 16, 16'hABCD, 16);
    check_eq("locked_sync", locked, 1'b1);
    check_eq("mono_1234_abcd", mono_sample, 16'hDF00);

    send_frame(16'h0003, 16, 16'h0000, 16);
    check_eq("mono_pos_odd", mono_sample, 16'h0001);
    send_frame(16'hFFFD, 16, 16'h0000, 16);
    check_eq("mono_neg_odd", mono_sample, 16'hFFFE);
    send_frame(16'h8000, 16, 16'h8000, 16);
    check_eq("mono_min", mono_sample, 16'h8000);
    send_frame(16'h7FFF, 16, 16'h7FFF, 16);
    check_eq("mono_max", mono_sample, 16'h7FFF);

    send_frame(16'h1111, 15, 16'h2222, 16);
    check_eq("errcnt_short_left", error_count, 8'(errs));
    check_eq("left_held_short", left_sample, 16'h7FFF);
    send_frame(16'h0F0F, 16, 16'h3C3C, 16);

    send_frame(16'h4444, 16, 16'h5A5A, 18);
    send_frame(16'h6666, 16, 16'h5A5A, 16);
    check_eq("right_after_long", right_sample, 16'h5A5A);

    err_q.push_back(edge_n + 32);
    errs++;
    repeat (40) drive_edge(1'b0, 1'($urandom));
    check_eq("locked_stuck", locked, 1'b0);
    check_eq("errcnt_stuck", error_count, 8'(errs));
    synced = 1'b0;
    send_frame(16'h0101, 16, 16'h0202, 16);
    check_eq("relocked", locked, 1'b1);
    send_frame(16'h0303, 16, 16'h0404, 16);

    for (int n = 0; n < 24; n++) begin
      send_frame(16'($urandom), 16, 16'($urandom), 16);
    end

    send_slot(1'b0, 16'hCAFE, 16);
    repeat (5) drive_edge(1'b1, 1'($urandom));
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    repeat (3) @(negedge serial_clk);
    reset  = 1'b0;
    synced = 1'b0;
    errs   = 0;
    send_frame(16'h1357, 16, 16'h2468, 16);
    check_eq("no_valid_after_reset", left_sample, 16'h0);
    send_frame(16'h1357, 16, 16'h2468, 16);
    check_eq("left_after_reset", left_sample, 16'h1357);

    repeat (4) drive_edge(1'b0, 1'($urandom));
    check_eq("pending_pairs", exp_q.size(), 0);
    check_eq("pending_errors", err_q.size(), 0);
    check_eq("final_errcnt", error_count, 8'(errs));
    check_eq("final_locked", locked, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
